// File: rtl/sram_bw_ctrl_pkg.sv
// Shared types for the SRAM byte-write controller.
package Thor2023Pkg;

   // Controller mode: CLEAR sweeps zeros over the whole array, RUN serves requests.
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/sram_bw_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   // ptr = 0 favours req[0] on a tie, ptr = 1 favours req[1]
   logic ptr;

   // a lone request always wins; a tie goes to the pointer side
   always_comb begin
      grant = req;
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
   end

   // after any grant, hand priority to the requester that lost out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         ptr <= 1'b0;
      else if (|grant)  ptr <= grant[0];
   end

endmodule

// File: rtl/sram_bw_ctrl.sv
// Two-writer / one-reader front end for a byte-enable SRAM with a full-array
// clear sweep. Writes are registered onto the SRAM port one cycle after ack;
// reads pass straight through and rd_vld tracks the 1-cycle SRAM latency.
module sram_bw_ctrl
   import Thor2023Pkg::*;
#(
   parameter  int WID  = 512,
   parameter  int DEP  = 256,
   localparam int NSEL = WID / 8,
   localparam int AW   = $clog2(DEP)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_req,
   output logic            busy,
   input  logic            m0_req,
   input  logic [NSEL-1:0] m0_sel,
   input  logic [AW-1:0]   m0_adr,
   input  logic [WID-1:0]  m0_dat,
   output logic            m0_ack,
   input  logic            m1_req,
   input  logic [NSEL-1:0] m1_sel,
   input  logic [AW-1:0]   m1_adr,
   input  logic [WID-1:0]  m1_dat,
   output logic            m1_ack,
   input  logic            rd_req,
   input  logic [AW-1:0]   rd_adr,
   output logic            rd_ack,
   output logic            rd_vld,
   output logic [WID-1:0]  rd_dat,
   output logic            sram_wr,
   output logic [NSEL-1:0] sram_sel,
   output logic [AW-1:0]   sram_wadr,
   output logic [WID-1:0]  sram_i,
   output logic [AW-1:0]   sram_radr,
   input  logic [WID-1:0]  sram_o
);

   localparam logic [AW-1:0] LAST = AW'(DEP - 1);

   state_e        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic [1:0]    arb_req, grant;

   // writers only compete in RUN, and a clear request locks them out that cycle
   assign arb_req = (state == RUN && !clr_req) ? {m1_req, m0_req} : 2'b00;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (arb_req),
      .grant (grant)
   );

   assign m0_ack    = grant[0];
   assign m1_ack    = grant[1];
   assign busy      = (state == CLEAR);
   assign rd_ack    = (state == RUN) && rd_req;
   assign sram_radr = rd_adr;
   assign rd_dat    = sram_o;

   // state and sweep counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // sweep advances one word per cycle; clr_req is only honoured from RUN
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLEAR: begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == LAST) state_nxt = RUN;
         end
         RUN: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // SRAM write port register: sweep zeros, or the granted requester's payload
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_wr   <= 1'b0;
         sram_sel  <= '0;
         sram_wadr <= '0;
         sram_i    <= '0;
      end else if (state == CLEAR) begin
         sram_wr   <= 1'b1;
         sram_sel  <= '1;
         sram_wadr <= cnt;
         sram_i    <= '0;
      end else if (grant[0]) begin
         sram_wr   <= 1'b1;
         sram_sel  <= m0_sel;
         sram_wadr <= m0_adr;
         sram_i    <= m0_dat;
      end else if (grant[1]) begin
         sram_wr   <= 1'b1;
         sram_sel  <= m1_sel;
         sram_wadr <= m1_adr;
         sram_i    <= m1_dat;
      end else begin
         sram_wr   <= 1'b0;
      end
   end

   // read data returns one cycle after the accepted request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_vld <= 1'b0;
      else      rd_vld <= rd_ack;
   end

endmodule

// File: tb/tb_sram_bw_ctrl.sv
// Directed bench for sram_bw_ctrl with a write-first byte-enable SRAM model.
module tb_sram_bw_ctrl;

   localparam int WID  = 512;
   localparam int DEP  = 256;
   localparam int NSEL = WID / 8;
   localparam int AW   = 8;

   typedef logic [WID-1:0] w_t;

   logic            clk, rst, clr_req, busy;
   logic            m0_req, m0_ack, m1_req, m1_ack;
   logic [NSEL-1:0] m0_sel, m1_sel, sram_sel;
   logic [AW-1:0]   m0_adr, m1_adr, rd_adr, sram_wadr, sram_radr;
   logic [WID-1:0]  m0_dat, m1_dat, rd_dat, sram_i, sram_o;
   logic            rd_req, rd_ack, rd_vld, sram_wr;

   logic [WID-1:0]  mem [DEP];
   logic [WID-1:0]  rd_tmp;

   int checks;
   int errors;

   sram_bw_ctrl #(.WID(WID), .DEP(DEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr_req   (clr_req),
      .busy      (busy),
      .m0_req    (m0_req),
      .m0_sel    (m0_sel),
      .m0_adr    (m0_adr),
      .m0_dat    (m0_dat),
      .m0_ack    (m0_ack),
      .m1_req    (m1_req),
      .m1_sel    (m1_sel),
      .m1_adr    (m1_adr),
      .m1_dat    (m1_dat),
      .m1_ack    (m1_ack),
      .rd_req    (rd_req),
      .rd_adr    (rd_adr),
      .rd_ack    (rd_ack),
      .rd_vld    (rd_vld),
      .rd_dat    (rd_dat),
      .sram_wr   (sram_wr),
      .sram_sel  (sram_sel),
      .sram_wadr (sram_wadr),
      .sram_i    (sram_i),
      .sram_radr (sram_radr),
      .sram_o    (sram_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM: byte-enable write, 1-cycle read, write data bypassed on same address
   always @(posedge clk) begin
      rd_tmp = mem[sram_radr];
      if (sram_wr) begin
         for (int b = 0; b < NSEL; b++) begin
            if (sram_sel[b]) begin
               mem[sram_wadr][b*8 +: 8] <= sram_i[b*8 +: 8];
               if (sram_wadr == sram_radr) rd_tmp[b*8 +: 8] = sram_i[b*8 +: 8];
            end
         end
      end
      sram_o <= rd_tmp;
   end

   task automatic chk(input string tag, input w_t obs, input w_t exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, w_t'(busy), w_t'(1));
      chk({tag, "_wr"},   w_t'(sram_wr), w_t'(0));
      chk({tag, "_wadr"}, w_t'(sram_wadr), w_t'(0));
      chk({tag, "_sel"},  w_t'(sram_sel), w_t'(0));
      chk({tag, "_i"},    sram_i, w_t'(0));
      chk({tag, "_vld"},  w_t'(rd_vld), w_t'(0));
      chk({tag, "_ack0"}, w_t'(m0_ack), w_t'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NSEL-1:0] ones;
      w_t              pat;
      ones    = '1;
      checks  = 0;
      errors  = 0;
      rst     = 1'b0;
      clr_req = 1'b0;
      m0_req  = 1'b0; m0_sel = '0; m0_adr = '0; m0_dat = '0;
      m1_req  = 1'b0; m1_sel = '0; m1_adr = '0; m1_dat = '0;
      rd_req  = 1'b0; rd_adr = '0;

      repeat (2) step();
      chk_reset("rst");

      // power-up sweep with a read held the whole time
      rd_req = 1'b1;
      rd_adr = 8'd3;
      rst    = 1'b1;
      for (int k = 0; k < DEP; k++) begin
         step();
         chk("sweep_wr",   w_t'(sram_wr), w_t'(1));
         chk("sweep_wadr", w_t'(sram_wadr), w_t'(k));
         chk("sweep_sel",  w_t'(sram_sel), w_t'(ones));
         chk("sweep_i",    sram_i, w_t'(0));
         chk("sweep_busy", w_t'(busy), w_t'(k != DEP - 1));
         chk("sweep_vld",  w_t'(rd_vld), w_t'(0));
         if (k != DEP - 1) chk("sweep_rdack", w_t'(rd_ack), w_t'(0));
      end
      rd_req = 1'b0;
      step();
      chk("idle_wr", w_t'(sram_wr), w_t'(0));

      // both writers held: m0, m1, m0, m1 ...
      m0_req = 1'b1; m0_adr = 8'd10; m0_sel = '1; m0_dat = w_t'(64'h1111);
      m1_req = 1'b1; m1_adr = 8'd20; m1_sel = '1; m1_dat = w_t'(64'h2222);
      #1;
      chk("rr_ack0_first", w_t'(m0_ack), w_t'(1));
      chk("rr_ack1_first", w_t'(m1_ack), w_t'(0));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_wr",   w_t'(sram_wr), w_t'(1));
         chk("rr_wadr", w_t'(sram_wadr), w_t'((i % 2) ? 20 : 10));
         chk("rr_i",    sram_i, (i % 2) ? w_t'(64'h2222) : w_t'(64'h1111));
         chk("rr_ack0", w_t'(m0_ack), w_t'((i % 2) == 1));
         chk("rr_ack1", w_t'(m1_ack), w_t'((i % 2) == 0));
      end
      m0_req = 1'b0;
      m1_req = 1'b0;

      // zero byte enables are still acked and issued
      m1_req = 1'b1; m1_sel = '0; m1_adr = 8'd30;
      #1;
      chk("sel0_ack1", w_t'(m1_ack), w_t'(1));
      chk("sel0_ack0", w_t'(m0_ack), w_t'(0));
      step();
      m1_req = 1'b0;
      chk("sel0_wr",   w_t'(sram_wr), w_t'(1));
      chk("sel0_sel",  w_t'(sram_sel), w_t'(0));
      chk("sel0_wadr", w_t'(sram_wadr), w_t'(30));

      // byte-0 write then read back through the bypass
      pat      = '1;
      pat[7:0] = 8'hAB;
      m0_req = 1'b1; m0_adr = 8'd5; m0_sel = NSEL'(1); m0_dat = pat;
      #1;
      chk("raw_ack0", w_t'(m0_ack), w_t'(1));
      step();
      m0_req = 1'b0;
      rd_req = 1'b1; rd_adr = 8'd5;
      #1;
      chk("raw_rdack", w_t'(rd_ack), w_t'(1));
      chk("raw_radr",  w_t'(sram_radr), w_t'(5));
      step();
      rd_req = 1'b0;
      chk("raw_vld", w_t'(rd_vld), w_t'(1));
      chk("raw_dat", rd_dat, w_t'(8'hAB));
      chk("raw_wr0", w_t'(sram_wr), w_t'(0));
      step();
      chk("raw_vld_drop", w_t'(rd_vld), w_t'(0));

      // clear request beats a held writer; a second clear mid-sweep is ignored
      m1_req = 1'b1; m1_adr = 8'd40; m1_sel = '1; m1_dat = w_t'(16'hBEEF);
      clr_req = 1'b1;
      #1;
      chk("clr_prio_ack1", w_t'(m1_ack), w_t'(0));
      step();
      clr_req = 1'b0;
      chk("clr_busy", w_t'(busy), w_t'(1));
      chk("clr_wr0",  w_t'(sram_wr), w_t'(0));
      chk("clr_ack1", w_t'(m1_ack), w_t'(0));
      for (int k = 0; k < DEP; k++) begin
         step();
         clr_req = (k == 50);
         chk("clr_wadr", w_t'(sram_wadr), w_t'(k));
         chk("clr_busyk", w_t'(busy), w_t'(k != DEP - 1));
         chk("clr_ack1k", w_t'(m1_ack), w_t'(k == DEP - 1));
      end
      clr_req = 1'b0;
      step();
      m1_req = 1'b0;
      chk("clr_m1_wr",   w_t'(sram_wr), w_t'(1));
      chk("clr_m1_wadr", w_t'(sram_wadr), w_t'(40));
      chk("clr_m1_i",    sram_i, w_t'(16'hBEEF));

      // leave pointer on m1, then reset in the middle of a sweep
      m0_req = 1'b1; m0_adr = 8'd7; m0_sel = '1;
      #1;
      chk("ptr_ack0", w_t'(m0_ack), w_t'(1));
      step();
      m0_req = 1'b0;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int k = 0; k <= 100; k++) step();
      chk("mid_wadr", w_t'(sram_wadr), w_t'(100));
      rst = 1'b0;
      #1;
      chk_reset("mid_rst");
      step();
      rst = 1'b1;
      step();
      chk("restart_wr",   w_t'(sram_wr), w_t'(1));
      chk("restart_wadr", w_t'(sram_wadr), w_t'(0));
      chk("restart_busy", w_t'(busy), w_t'(1));
      for (int n = 0; n < 300 && busy; n++) step();
      chk("restart_done", w_t'(busy), w_t'(0));

      // pointer is back on m0 after reset
      m0_req = 1'b1; m1_req = 1'b1;
      #1;
      chk("ptr_rst_ack0", w_t'(m0_ack), w_t'(1));
      chk("ptr_rst_ack1", w_t'(m1_ack), w_t'(0));
      step();
      m0_req = 1'b0; m1_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
